trng_health_packer: RTL
=======================

# trng_health_packer

Entropy front-end that sits directly upstream of the RNG word assembler. It accepts a raw bit stream from the ring-oscillator sampler and runs continuous health tests on every sample. It packs accepted bits into TRNG_WIDTH-bit words and delivers them to the assembler over the trng_req / trng_word / trng_valid interface. On any health-test failure it latches a sticky fault, flushes buffered entropy and withholds output until software clears the fault.

## Interface
- TRNG_WIDTH, 4, packed word width; must match the assembler's TRNG_WIDTH; ≥1.
- RCT_CUTOFF, 8, repetition-count cutoff: a run of this many identical raw bits is a failure; ≥2.
- APT_WINDOW, 64, adaptive-proportion window length in raw bits; ≥2.
- APT_CUTOFF, 56, adaptive-proportion cutoff: this many matches of the reference bit within one window is a failure; 2 ≤ APT_CUTOFF ≤ APT_WINDOW.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- en  in  1  block enable; when low, raw bits are ignored and all state holds.
- raw_bit  in  1  raw entropy sample.
- raw_valid  in  1  raw_bit is valid this cycle; the source is free-running, with no backpressure.
- trng_req  in  1  assembler wants a word.
- trng_word  out  TRNG_WIDTH  packed word; 0 whenever trng_valid is 0.
- trng_valid  out  1  word transfer occurs this cycle.
- clear_fail  in  1  single-cycle pulse that clears the sticky fault.
- health_fail  out  1  sticky fault flag.
- fail_cause  out  2  sticky cause: bit0 = RCT, bit1 = APT.

## Operation
- A raw bit is accepted on an edge where `en && raw_valid`. Health tests see every accepted bit, regardless of buffer state.
- Packer
  - Shift register, MSB-first: `pack = {pack[W-2:0], raw_bit}`.
  - pack_cnt counts 0..TRNG_WIDTH-1.
  - On the TRNG_WIDTH-th bit, the completed word moves to a one-entry holding register (hold_full=1) and pack_cnt returns to 0.
- Holding register
  - If the holding register is full and not transferring when a word completes, the new word is dropped and packing restarts. Entropy is never stalled.
- Transfer
  - `trng_valid = en && trng_req && hold_full && !health_fail`, combinational from registered state.
  - trng_word equals the holding register when trng_valid=1, else 0.
  - A transfer empties the holding register at that edge.
  - Transfer and word completion in the same cycle: the new word is loaded and hold_full stays 1.
- RCT
  - run_cnt is 1 on the first accepted bit after reset or clear.
  - run_cnt increments when the bit equals the previous bit, otherwise reloads to 1.
  - Failure at the edge where run_cnt would reach RCT_CUTOFF.
- APT (only when compiled in)
  - The first bit of each window is the reference bit; match_cnt starts at 1.
  - Each following bit that equals the reference increments match_cnt.
  - Failure when match_cnt reaches APT_CUTOFF.
  - After APT_WINDOW bits, the next bit starts a new window.
- Failure handling
  - health_fail is set and the corresponding fail_cause bit is set.
  - pack, pack_cnt and hold_full are cleared, and the completing word (if any) is discarded.
  - While failed, raw bits still run the tests, but nothing is packed.
- clear_fail
  - Clears health_fail, fail_cause, the packer, the holding register, run_cnt and the APT window.
  - The next accepted bit restarts both tests.
  - A failure detected in the same cycle as clear_fail wins: the flag stays set with the new cause.
- en low: no bits accepted, trng_valid=0, all counters and registers hold. clear_fail still acts.

## Timing
- Reset values: trng_word=0, trng_valid=0, health_fail=0, fail_cause=0, all counters 0, hold_full=0.
- Latency: trng_valid can assert in the cycle after the edge that accepts the TRNG_WIDTH-th bit, provided trng_req=1 in that cycle.
- trng_valid lasts one cycle per word. It never asserts twice for the same word.
- health_fail rises the cycle after the failing bit's edge. trng_valid is 0 from that cycle on.
- Reset asserted mid-word discards the partial word asynchronously. Operation resumes on the first accepted bit after reset deasserts.
- Counter widths are $clog2(cutoff+1). Counters never wrap, because a failure fires before overflow.

## Configuration
- TRNG_HEALTH_APT_EN
  - Defined: the APT logic is compiled in, fail_cause[1] is live, and APT_WINDOW/APT_CUTOFF are used.
  - Undefined: the APT logic is absent, fail_cause[1] is tied 0, APT parameters are ignored, and only RCT can fail.

## Test plan
- Reset, then feed raw bits 1,0,1,1 with trng_req=1 → trng_valid pulses once, one cycle after the 4th bit, with trng_word=4'b1011; it then stays 0.
- trng_req=0 while 8 alternating bits (1,0,...) arrive → the first word 4'b1010 is held; the second word (also 4'b1010) is dropped. Raise trng_req → exactly one transfer of 4'b1010.
- Feed 7 ones then a 0 → no fault. Feed 8 consecutive ones → health_fail=1 and fail_cause=2'b01 one cycle after the 8th bit; trng_valid stays 0 even with trng_req=1.
- With TRNG_HEALTH_APT_EN and the pattern (1,1,1,1,1,1,1,0) repeated → RCT never fires. The APT fault (fail_cause=2'b10) sets at the 56th matching 1 within the 64-bit window. Without the macro, no fault occurs.
- After a fault, pulse clear_fail → flags are 0; the next 4 bits 0,1,1,0 deliver trng_word=4'b0110. clear_fail coinciding with a failing bit → health_fail stays 1.
- Assert reset asynchronously after 2 of 4 bits → outputs go to 0 immediately. After deassert, the next 4 bits 1,1,0,0 give trng_word=4'b1100, with the stale partial bits absent.

Source files
------------

// File: rtl/trng_health_packer.sv
// trng_health_packer: health-tested entropy packer feeding the RNG word assembler.
// Runs a repetition-count test (and optionally an adaptive-proportion test) on every
// accepted raw bit, packs bits MSB-first into TRNG_WIDTH-bit words and hands them out
// through a one-entry holding register. Any health failure latches a sticky fault.
// Optional feature macro: TRNG_HEALTH_APT_EN compiles in the adaptive-proportion test.
module trng_health_packer #(
    parameter int unsigned TRNG_WIDTH = 4,
    parameter int unsigned RCT_CUTOFF = 8,
    parameter int unsigned APT_WINDOW = 64,
    parameter int unsigned APT_CUTOFF = 56
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  raw_bit,
    input  logic                  raw_valid,
    input  logic                  trng_req,
    output logic [TRNG_WIDTH-1:0] trng_word,
    output logic                  trng_valid,
    input  logic                  clear_fail,
    output logic                  health_fail,
    output logic [1:0]            fail_cause
);
    localparam int unsigned W          = TRNG_WIDTH;
    localparam int unsigned PACK_CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned RUN_CNT_W  = $clog2(RCT_CUTOFF + 1);

    logic [W-1:0]          pack_q, pack_d;
    logic [PACK_CNT_W-1:0] pack_cnt_q, pack_cnt_d;
    logic [W-1:0]          hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [RUN_CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic                  prev_bit_q, prev_bit_d;
    logic                  health_fail_d;
    logic [1:0]            fail_cause_d;
    logic                  accept;
    logic                  rct_fail;
    logic                  apt_fail;
    logic [1:0]            new_cause;
    logic [W-1:0]          pack_shift;

    assign accept     = en && raw_valid;
    assign trng_valid = en && trng_req && hold_full_q && !health_fail;
    assign trng_word  = trng_valid ? hold_q : '0;

    // Repetition-count test: run length of identical bits, saturating at the cutoff.
    always_comb begin
        run_cnt_d  = run_cnt_q;
        prev_bit_d = prev_bit_q;
        rct_fail   = 1'b0;
        if (accept) begin
            prev_bit_d = raw_bit;
            if ((run_cnt_q != '0) && (raw_bit == prev_bit_q)) begin
                if (run_cnt_q < RUN_CNT_W'(RCT_CUTOFF)) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
                rct_fail = (run_cnt_q >= RUN_CNT_W'(RCT_CUTOFF - 1));
            end else begin
                run_cnt_d = RUN_CNT_W'(1);
            end
        end
        if (clear_fail) begin
            run_cnt_d = '0;
        end
    end

`ifdef TRNG_HEALTH_APT_EN
    localparam int unsigned WIN_CNT_W   = $clog2(APT_WINDOW + 1);
    localparam int unsigned MATCH_CNT_W = $clog2(APT_CUTOFF + 1);

    logic [WIN_CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic                   ref_bit_q, ref_bit_d;

    // Adaptive-proportion test: count matches of the window's first bit.
    always_comb begin
        win_cnt_d   = win_cnt_q;
        match_cnt_d = match_cnt_q;
        ref_bit_d   = ref_bit_q;
        apt_fail    = 1'b0;
        if (accept) begin
            if ((win_cnt_q == '0) || (win_cnt_q == WIN_CNT_W'(APT_WINDOW))) begin
                win_cnt_d   = WIN_CNT_W'(1);
                match_cnt_d = MATCH_CNT_W'(1);
                ref_bit_d   = raw_bit;
            end else begin
                win_cnt_d = win_cnt_q + 1'b1;
                if (raw_bit == ref_bit_q) begin
                    if (match_cnt_q < MATCH_CNT_W'(APT_CUTOFF)) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                    apt_fail = (match_cnt_q >= MATCH_CNT_W'(APT_CUTOFF - 1));
                end
            end
        end
        if (clear_fail) begin
            win_cnt_d   = '0;
            match_cnt_d = '0;
        end
    end

    // APT window state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt_q   <= '0;
            match_cnt_q <= '0;
            ref_bit_q   <= 1'b0;
        end else if (en || clear_fail) begin
            win_cnt_q   <= win_cnt_d;
            match_cnt_q <= match_cnt_d;
            ref_bit_q   <= ref_bit_d;
        end
    end
`else
    // APT compiled out; its parameters are accepted but never influence the result.
    assign apt_fail = 1'b0 && (APT_CUTOFF <= APT_WINDOW);
`endif

    // Packer, holding register and sticky fault next-state.
    always_comb begin
        pack_shift    = W'({pack_q, raw_bit});
        new_cause     = {apt_fail, rct_fail};
        pack_d        = pack_q;
        pack_cnt_d    = pack_cnt_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q && !trng_valid;
        health_fail_d = health_fail | (|new_cause);
        fail_cause_d  = fail_cause | new_cause;
        if (clear_fail || (|new_cause)) begin
            pack_d      = '0;
            pack_cnt_d  = '0;
            hold_full_d = 1'b0;
            if (clear_fail) begin
                health_fail_d = |new_cause;
                fail_cause_d  = new_cause;
            end
        end else if (accept && !health_fail) begin
            if (pack_cnt_q == PACK_CNT_W'(W - 1)) begin
                pack_d     = '0;
                pack_cnt_d = '0;
                if (!hold_full_d) begin
                    hold_d      = pack_shift;
                    hold_full_d = 1'b1;
                end
            end else begin
                pack_d     = pack_shift;
                pack_cnt_d = pack_cnt_q + 1'b1;
            end
        end
    end

    // State registers; everything holds while disabled unless a clear arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pack_q      <= '0;
            pack_cnt_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            run_cnt_q   <= '0;
            prev_bit_q  <= 1'b0;
            health_fail <= 1'b0;
            fail_cause  <= 2'b00;
        end else if (en || clear_fail) begin
            pack_q      <= pack_d;
            pack_cnt_q  <= pack_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            run_cnt_q   <= run_cnt_d;
            prev_bit_q  <= prev_bit_d;
            health_fail <= health_fail_d;
            fail_cause  <= fail_cause_d;
        end
    end
endmodule
